// File: rtl/dcim_pkg.sv
// Shared defaults and types for the bit-serial shift-accumulate block.
// Holds parameter defaults, the control state enum and a counter-width helper.
package dcim_pkg;

    localparam int PSUM_W_DEF  = 27;
    localparam int ACC_W_DEF   = 51;
    localparam int IN_BITS_DEF = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sa_state_t;

    // Beat counter width; never zero even for a single-beat configuration.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_addsub.sv
// Combinational beat datapath: sign-extend a partial sum, weight it by its
// bit position and either load, add or subtract it against the accumulator.
module sa_addsub #(
    parameter int PSUM_W = 27,
    parameter int ACC_W  = 51,
    parameter int CNT_W  = 3
) (
    input  logic [PSUM_W-1:0] i_psum,
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [CNT_W-1:0]  i_shamt,
    input  logic              i_first,
    input  logic              i_subtract,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_base;

    // Weighted term and wrap-around add/subtract; the first beat starts from zero.
    always_comb begin
        w_ext  = {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum};
        w_term = w_ext << i_shamt;
        if (i_first) begin
            w_base = {ACC_W{1'b0}};
        end else begin
            w_base = i_acc;
        end
        if (i_subtract) begin
            o_sum = w_base - w_term;
        end else begin
            o_sum = w_base + w_term;
        end
    end

endmodule

// File: rtl/shift_acc.sv
// Bit-serial shift-accumulator: folds IN_BITS partial-sum beats (LSB first)
// into one signed result and holds it until the consumer takes it.
module shift_acc #(
    parameter int PSUM_W  = dcim_pkg::PSUM_W_DEF,
    parameter int ACC_W   = dcim_pkg::ACC_W_DEF,
    parameter int IN_BITS = dcim_pkg::IN_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_clr,
    input  logic              in_signed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);

    import dcim_pkg::*;

    localparam int               CNT_W    = cnt_width(IN_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_BITS - 1);

    sa_state_t        r_state;
    sa_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_data;
    logic             r_sign;

    logic             w_beat;
    logic             w_first;
    logic             w_last;
    logic             w_sub;
    logic             w_xfer;
    logic [ACC_W-1:0] w_sum;

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;

    // acc_clr blocks the beat so an aborted cycle never touches the accumulator.
    assign w_beat  = in_valid && in_ready && !acc_clr;
    assign w_xfer  = out_valid && out_ready;
    assign w_first = (r_cnt == {CNT_W{1'b0}});
    assign w_last  = (r_cnt == LAST_CNT);
    // On a single-beat configuration the sign flag is not latched yet, so use the live input.
    assign w_sub   = w_last && (w_first ? in_signed : r_sign);

    sa_addsub #(
        .PSUM_W (PSUM_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_addsub (
        .i_psum     (psum),
        .i_acc      (r_acc),
        .i_shamt    (r_cnt),
        .i_first    (w_first),
        .i_subtract (w_sub),
        .o_sum      (w_sum)
    );

    // Next-state and beat-counter logic; acc_clr overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (acc_clr) begin
            w_state_nxt = ACCUM;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_beat) begin
                        if (w_last) begin
                            w_state_nxt = HOLD;
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end else begin
                            w_state_nxt = ACCUM;
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ACCUM;
                        w_cnt_nxt   = r_cnt;
                    end
                end
                HOLD: begin
                    if (w_xfer) begin
                        w_state_nxt = ACCUM;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = r_cnt;
                    end
                end
                default: begin
                    w_state_nxt = ACCUM;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Accumulator, latched sign flag and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= {ACC_W{1'b0}};
            r_sign     <= 1'b0;
            r_out_data <= {ACC_W{1'b0}};
        end else begin
            if (w_beat) begin
                r_acc <= w_sum;
            end
            if (w_beat && w_first) begin
                r_sign <= in_signed;
            end
            if (w_beat && w_last) begin
                r_out_data <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_shift_acc.sv
// Self-checking bench for shift_acc: directed corner cases plus randomized
// traffic compared against a queue-based arithmetic reference model.
module tb_shift_acc;

    import dcim_pkg::*;

    localparam int PSUM_W  = PSUM_W_DEF;
    localparam int ACC_W   = ACC_W_DEF;
    localparam int IN_BITS = IN_BITS_DEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_clr;
    logic              in_signed;
    logic              in_valid;
    logic              in_ready;
    logic [PSUM_W-1:0] psum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state: beats collected so far, latched sign, pending result.
    longint           m_q[$];
    bit               m_sign = 1'b0;
    bit               m_hold = 1'b0;
    logic [ACC_W-1:0] m_exp  = '0;

    always #5 clk = ~clk;

    shift_acc dut (
        .clk       (clk),
        .rst       (rst),
        .acc_clr   (acc_clr),
        .in_signed (in_signed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum      (psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Result = sum of psum[i]*2^i, with the top bit weight negative for signed activations.
    function automatic logic [ACC_W-1:0] ref_result(input bit sgn, input longint q[$]);
        longint total = 0;
        longint one   = 1;
        longint w;
        for (int i = 0; i < IN_BITS; i++) begin
            w = q[i] * (one <<< i);
            if (sgn && (i == IN_BITS - 1)) total -= w;
            else                           total += w;
        end
        return total[ACC_W-1:0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sign = 1'b0;
        m_hold = 1'b0;
        m_exp  = '0;
    endtask

    // Advance the model by one edge using the current inputs, then clock and compare.
    task automatic cycle();
        if (acc_clr) begin
            m_q.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            if (m_q.size() == 0) m_sign = in_signed;
            m_q.push_back(longint'($signed(psum)));
            if (m_q.size() == IN_BITS) begin
                m_exp  = ref_result(m_sign, m_q);
                m_hold = 1'b1;
                m_q.delete();
            end
        end
        @(posedge clk);
        #1;
        check_eq("in_ready", 64'(in_ready), 64'(!m_hold));
        check_eq("out_valid", 64'(out_valid), 64'(m_hold));
        if (m_hold) check_eq("out_data", 64'(out_data), 64'(m_exp));
    endtask

    task automatic beats(input bit sgn, input longint val, input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_signed = sgn;
            psum      = PSUM_W'(val);
            out_ready = rdy;
            cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        longint one = 1;
        longint e;
        logic [ACC_W-1:0] all_ones;

        rst       = 1'b1;
        acc_clr   = 1'b0;
        in_signed = 1'b0;
        in_valid  = 1'b0;
        psum      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));

        // Unsigned ones: 255, valid one cycle after the last beat, then dropped.
        beats(1'b0, 1, 8, 1'b1);
        check_eq("uns_ones", 64'(out_data), 64'(255));
        out_ready = 1'b1;
        cycle();
        check_eq("uns_ones_xfer", 64'(out_valid), 64'(0));

        // Signed ones: -1.
        beats(1'b1, 1, 8, 1'b1);
        all_ones = '1;
        check_eq("sgn_ones", 64'(out_data), 64'(all_ones));
        cycle();

        // Unsigned most-negative psum.
        beats(1'b0, -(one <<< 26), 8, 1'b1);
        e = -255 * (one <<< 26);
        check_eq("uns_minneg", 64'(out_data), 64'(e[ACC_W-1:0]));
        cycle();

        // Backpressure: held result, beats refused, taken on the 4th cycle.
        beats(1'b0, 3, 8, 1'b0);
        in_valid  = 1'b1;
        psum      = PSUM_W'(5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("bp_stable", 64'(out_data), 64'(765));
            check_eq("bp_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check_eq("bp_released", 64'(in_ready), 64'(1));
        beats(1'b0, 4, 8, 1'b1);
        check_eq("bp_next", 64'(out_data), 64'(1020));
        cycle();

        // Abort after four beats, concurrent with in_valid.
        beats(1'b0, 7, 4, 1'b1);
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        cycle();
        acc_clr = 1'b0;
        beats(1'b0, 2, 8, 1'b1);
        check_eq("clr_510", 64'(out_data), 64'(510));
        cycle();

        // Asynchronous reset while holding a result.
        beats(1'b0, 9, 8, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_hold_valid", 64'(out_valid), 64'(0));
        check_eq("rst_hold_data", 64'(out_data), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_hold_ready", 64'(in_ready), 64'(1));
        beats(1'b1, -3, 8, 1'b1);
        check_eq("rst_hold_after", 64'(out_data), 64'(3));
        cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            acc_clr   = ($urandom_range(0, 99) < 3);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_signed = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       psum = {1'b0, {(PSUM_W-1){1'b1}}};
                1:       psum = {1'b1, {(PSUM_W-1){1'b0}}};
                default: psum = PSUM_W'($urandom);
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
